// File: rtl/oc_bus_master.sv
// Single-master initiator for an open-collector MSYN/SSYN async bus; bus lines are only ever driven 0 or z.
// Optional feature macro OC_BUS_RETRY_EN: one automatic rerun of the cycle after an ASSERT-phase timeout.
module oc_bus_master #(
    parameter int AW      = 18,
    parameter int DW      = 16,
    parameter int DESKEW  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          timeout,
    inout  wire  [AW-1:0] bus_a_n,
    inout  wire  [DW-1:0] bus_d_n,
    output wire           bus_c1_n,
    output wire           bus_msyn_n,
    input  logic          bus_ssyn_n
);

    localparam int CNT_MAX = (TIMEOUT > DESKEW) ? TIMEOUT : DESKEW;
    localparam int CW      = ($clog2(CNT_MAX + 1) > 8) ? $clog2(CNT_MAX + 1) : 8;
    localparam logic [CW-1:0] DSK_LAST = CW'(DESKEW - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ASSERT,
        S_CAPTURE,
        S_RELEASE,
        S_HOLD,
        S_RETRY
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          timeout_q;
    logic [DW-1:0] rdata_q;
    logic          drv_q;
    logic          msyn_q;
    logic          ssyn_s1_q;
    logic          ssyn_s2_q;
    logic [DW-1:0] d_s1_q;
    logic [DW-1:0] d_s2_q;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
`ifdef OC_BUS_RETRY_EN
    logic          rerun_q;
    logic          second_q;
`endif

    // Open-collector drivers: a logic 1 pulls the line low, otherwise release it.
    for (genvar i = 0; i < AW; i++) begin : g_abus
        assign bus_a_n[i] = (drv_q && addr_q[i]) ? 1'b0 : 1'bz;
    end
    for (genvar i = 0; i < DW; i++) begin : g_dbus
        assign bus_d_n[i] = (drv_q && wr_q && wdata_q[i]) ? 1'b0 : 1'bz;
    end
    assign bus_c1_n   = (drv_q && wr_q) ? 1'b0 : 1'bz;
    assign bus_msyn_n = msyn_q ? 1'b0 : 1'bz;

    assign busy    = busy_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign timeout = timeout_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ssyn_s1_q <= 1'b1;
            ssyn_s2_q <= 1'b1;
        end else begin
            ssyn_s1_q <= bus_ssyn_n;
            ssyn_s2_q <= ssyn_s1_q;
        end
    end

    // Data path: read data rides the same two-flop delay as SSYN so it is settled at CAPTURE.
    always_ff @(posedge clk) begin
        d_s1_q <= bus_d_n;
        d_s2_q <= d_s1_q;
        if (state_q == S_IDLE && req) begin
            wr_q    <= wr;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            rdata_q   <= '0;
            drv_q     <= 1'b0;
            msyn_q    <= 1'b0;
`ifdef OC_BUS_RETRY_EN
            rerun_q   <= 1'b0;
            second_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                        drv_q     <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= S_SETUP;
`ifdef OC_BUS_RETRY_EN
                        rerun_q   <= 1'b0;
                        second_q  <= 1'b0;
`endif
                    end
                end
                S_SETUP: begin
                    if (cnt_q >= DSK_LAST) begin
                        cnt_q   <= '0;
                        msyn_q  <= 1'b1;
                        state_q <= S_ASSERT;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_ASSERT: begin
                    // A responder already holding SSYN low counts as an immediate reply.
                    if (!ssyn_s2_q) begin
                        state_q <= S_CAPTURE;
                    end else if (cnt_q >= TO_LAST) begin
                        msyn_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_RELEASE;
`ifdef OC_BUS_RETRY_EN
                        if (second_q) begin
                            timeout_q <= 1'b1;
                        end else begin
                            rerun_q <= 1'b1;
                        end
`else
                        timeout_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_CAPTURE: begin
                    if (!wr_q) begin
                        rdata_q <= ~d_s2_q;
                    end
                    msyn_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (ssyn_s2_q) begin
                        cnt_q   <= '0;
                        state_q <= S_HOLD;
                    end else if (cnt_q >= TO_LAST) begin
                        timeout_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_HOLD: begin
                    if (cnt_q >= DSK_LAST) begin
                        cnt_q <= '0;
                        drv_q <= 1'b0;
`ifdef OC_BUS_RETRY_EN
                        if (rerun_q) begin
                            rerun_q  <= 1'b0;
                            second_q <= 1'b1;
                            state_q  <= S_RETRY;
                        end else begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
`else
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
`ifdef OC_BUS_RETRY_EN
                S_RETRY: begin
                    // Bus stays released for DESKEW cycles before the latched request is replayed.
                    if (cnt_q >= DSK_LAST) begin
                        cnt_q   <= '0;
                        drv_q   <= 1'b1;
                        state_q <= S_SETUP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oc_bus_master.sv
// Scoreboard bench for oc_bus_master: directed bus cycles against a behavioural responder on pulled-up lines.
module tb_oc_bus_master;

    localparam int AW      = 18;
    localparam int DW      = 16;
    localparam int DESKEW  = 4;
    localparam int TIMEOUT = 20;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          req     = 1'b0;
    logic          wr      = 1'b0;
    logic [AW-1:0] addr    = '0;
    logic [DW-1:0] wdata   = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] rdata;
    logic          timeout;
    tri1  [AW-1:0] bus_a_n;
    tri1  [DW-1:0] bus_d_n;
    tri1           bus_c1_n;
    tri1           bus_msyn_n;
    logic          bus_ssyn_n;

    logic          rsp_en   = 1'b0;
    logic          rsp_rd   = 1'b0;
    int            rsp_d    = 0;
    int            rsp_r    = 0;
    logic [DW-1:0] rsp_data = '0;
    logic          rsp_drv  = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          to;
        int            np;
        int            mlen;
        int            lat;
        int            t_req;
    } exp_t;

    exp_t sb[$];

    oc_bus_master #(
        .AW(AW), .DW(DW), .DESKEW(DESKEW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .timeout(timeout),
        .bus_a_n(bus_a_n), .bus_d_n(bus_d_n), .bus_c1_n(bus_c1_n),
        .bus_msyn_n(bus_msyn_n), .bus_ssyn_n(bus_ssyn_n)
    );

    for (genvar i = 0; i < DW; i++) begin : g_rsp
        assign bus_d_n[i] = (rsp_drv && rsp_data[i]) ? 1'b0 : 1'bz;
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Responder: answers MSYN after rsp_d negedges, releases SSYN rsp_r negedges after MSYN rises.
    initial begin
        int n;
        bus_ssyn_n = 1'b1;
        forever begin
            @(negedge clk);
            if (rsp_en && reset_n && bus_msyn_n == 1'b0) begin
                for (int k = 0; k < rsp_d; k++) @(negedge clk);
                bus_ssyn_n = 1'b0;
                rsp_drv    = rsp_rd;
                n = 0;
                while (bus_msyn_n == 1'b0 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                for (int k = 0; k < rsp_r; k++) @(negedge clk);
                bus_ssyn_n = 1'b1;
                rsp_drv    = 1'b0;
            end
        end
    end

    // Monitor: tracks bus behaviour per transaction and pops the scoreboard on every done.
    initial begin
        int   np, run, mlen, pre, post, win_bad;
        bit   post_ok;
        logic msyn_prev;
        exp_t e;
        np = 0; run = 0; mlen = 0; pre = 0; post = 0; win_bad = 0; post_ok = 1; msyn_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                np = 0; run = 0; mlen = 0; pre = 0; post = 0; win_bad = 0; post_ok = 1; msyn_prev = 1'b1;
            end else begin
                if (bus_msyn_n == 1'b0) begin
                    if (msyn_prev) begin
                        np++;
                        post    = 0;
                        post_ok = 1;
                    end
                    run++;
                end else if (!msyn_prev) begin
                    mlen = run;
                    run  = 0;
                end
                msyn_prev = bus_msyn_n;
                if (busy && sb.size() > 0) begin
                    e = sb[0];
                    if (bus_a_n != '1) begin
                        if (bus_a_n != ~e.addr) win_bad++;
                        if (e.wr && (bus_d_n != ~e.wdata || bus_c1_n != 1'b0)) win_bad++;
                        if (!e.wr && bus_c1_n != 1'b1) win_bad++;
                    end
                    if (bus_msyn_n == 1'b0 && bus_a_n != ~e.addr) win_bad++;
                    if (bus_msyn_n == 1'b1) begin
                        if (np == 0) begin
                            if (bus_a_n == ~e.addr) pre++;
                        end else if (post_ok && bus_a_n == ~e.addr) begin
                            post++;
                        end else begin
                            post_ok = 0;
                        end
                    end
                end
                if (done) begin
                    check("done_expected", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("rdata", rdata, e.rdata);
                        check("timeout", timeout, e.to);
                        check("msyn_pulses", np, e.np);
                        check("msyn_len", mlen, e.mlen);
                        check("latency", cyc - e.t_req, e.lat);
                        check("addr_pre_msyn", pre, DESKEW);
                        check("addr_post_msyn_ok", post >= DESKEW, 1);
                        check("drive_window_errs", win_bad, 0);
                        check("released_at_done", {bus_a_n, bus_d_n, bus_c1_n, bus_msyn_n}, 36'hF_FFFF_FFFF);
                        check("busy_at_done", busy, 0);
                    end
                    np = 0; run = 0; mlen = 0; pre = 0; post = 0; win_bad = 0; post_ok = 1;
                end
            end
        end
    end

    task automatic run_vec(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic ren, input int rd, input int rr, input logic [DW-1:0] rdat,
                           input logic [DW-1:0] x_rdata, input logic x_to, input int x_np,
                           input int x_mlen, input int x_lat, input logic hold);
        exp_t e;
        int   n;
        @(negedge clk);
        rsp_en   = ren;
        rsp_rd   = !w;
        rsp_d    = rd;
        rsp_r    = rr;
        rsp_data = rdat;
        e.wr = w; e.addr = a; e.wdata = d; e.rdata = x_rdata; e.to = x_to;
        e.np = x_np; e.mlen = x_mlen; e.lat = x_lat; e.t_req = cyc;
        sb.push_back(e);
        wr = w; addr = a; wdata = d; req = 1'b1;
        @(negedge clk);
        if (!hold) req = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_timeout_clear", timeout, 0);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        req = 1'b0;
        check("done_seen", done, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
`ifdef OC_BUS_RETRY_EN
        localparam int TO_NP  = 2;
        localparam int TO_LAT = 63;
`else
        localparam int TO_NP  = 1;
        localparam int TO_LAT = 30;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 0);
        check("rst_timeout", timeout, 0);
        check("rst_released", {bus_a_n, bus_d_n, bus_c1_n, bus_msyn_n}, 36'hF_FFFF_FFFF);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // w, addr, wdata, rsp_en, rsp_d, rsp_r, rsp_data, exp rdata, exp to, np, mlen, lat, hold
        run_vec(1'b0, 18'o172340, 16'o000000, 1'b1, 3, 0,  16'o123456, 16'o123456, 1'b0, 1, 7, 19, 1'b0);
        run_vec(1'b0, 18'o000777, 16'o000000, 1'b1, 0, 0,  16'o052525, 16'o052525, 1'b0, 1, 4, 16, 1'b0);
        run_vec(1'b1, 18'o777560, 16'o000101, 1'b1, 1, 0,  16'o000000, 16'o052525, 1'b0, 1, 5, 17, 1'b0);
        run_vec(1'b0, 18'o012345, 16'o000000, 1'b0, 0, 0,  16'o000000, 16'o052525, 1'b1, TO_NP, 20, TO_LAT, 1'b0);
        run_vec(1'b1, 18'o100000, 16'o177777, 1'b1, 0, 50, 16'o000000, 16'o052525, 1'b1, 1, 4, 33, 1'b0);
        n = 0;
        while (bus_ssyn_n != 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("responder_idle", bus_ssyn_n, 1);
        repeat (3) @(negedge clk);

        // Reset pulsed while MSYN is asserted.
        rsp_en = 1'b0;
        wr = 1'b0; addr = 18'o054321; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (bus_msyn_n != 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_msyn_low", bus_msyn_n, 0);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_released", {bus_a_n, bus_d_n, bus_c1_n, bus_msyn_n}, 36'hF_FFFF_FFFF);
        check("midrst_rdata", rdata, 0);
        check("midrst_timeout", timeout, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_vec(1'b0, 18'o000100, 16'o000000, 1'b1, 0, 0,  16'o000001, 16'o000001, 1'b0, 1, 4, 16, 1'b0);
        run_vec(1'b0, 18'o000002, 16'o000000, 1'b0, 0, 0,  16'o000000, 16'o000001, 1'b1, TO_NP, 20, TO_LAT, 1'b1);
        repeat (10) @(negedge clk);
        check("held_req_no_reaccept", busy, 0);
        run_vec(1'b0, 18'o000003, 16'o000000, 1'b1, 0, 0,  16'o031415, 16'o031415, 1'b0, 1, 4, 16, 1'b0);

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/oc_bus_master.md
Name: oc_bus_master

Overview:
- Single-master initiator on a wired-AND, open-collector async bus (Unibus-style MSYN/SSYN). The bus lines are held high by external pullup packs.
- Converts a one-cycle local request into a complete bus read or write cycle: address/data setup deskew, MSYN assertion, wait for SSYN from the responder, data capture, release, and timeout.
- Drives every bus line only with 0 or z, never 1. Asserted = low.

Parameters:
- AW, 18, bus address width
- DW, 16, bus data width
- DESKEW, 4, clk cycles that address/data are held before MSYN asserts and after MSYN releases (≥1)
- TIMEOUT, 255, clk cycles to wait for SSYN assert or deassert before aborting (≥2)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  1  start cycle; sampled only in IDLE
- wr  in  1  1 = write, 0 = read; captured with req
- addr  in  AW  cycle address; captured with req
- wdata  in  DW  write data; captured with req
- busy  out  1  cycle in progress
- done  out  1  one-cycle pulse at cycle completion (success or timeout)
- rdata  out  DW  read data captured from bus
- timeout  out  1  sticky abort flag; cleared by next accepted req
- bus_a_n  inout  AW  open-collector address, inverted sense
- bus_d_n  inout  DW  open-collector data, inverted sense
- bus_c1_n  out  1  open-collector write strobe (0 = write)
- bus_msyn_n  out  1  open-collector master sync
- bus_ssyn_n  in  1  slave sync from responder, active low; resynchronised through 2 flops

Behaviour:
- Reset (async, reset_n low): state IDLE, busy=0, done=0, rdata=0, timeout=0. All bus outputs z. Applies immediately mid-cycle; the bus is released in the same instant.
- Drive rule: bit driven 0 when logically asserted, else z. Bus reads treat z/1 as deasserted.
- IDLE:
  - req=1 latches wr/addr/wdata.
  - Clears timeout, sets busy.
  - Goes to SETUP.
- SETUP:
  - Drives address; on a write also drives data and c1.
  - Counts DESKEW cycles, then goes to ASSERT.
- ASSERT:
  - Drives msyn_n=0 and starts the timeout counter.
  - Synced SSYN low → go to CAPTURE.
  - Counter reaches TIMEOUT → set timeout, go to RELEASE.
- CAPTURE:
  - One cycle.
  - On a read, rdata ← ~bus_d_n. The data line is resynchronised on the same 2-flop path as SSYN, so data is stable.
  - Goes to RELEASE.
- RELEASE:
  - msyn_n goes to z; address/data are still driven.
  - Waits for synced SSYN high, or TIMEOUT cycles. A timeout here also sets timeout.
  - Goes to HOLD.
- HOLD:
  - Address/data held DESKEW cycles, then all bus lines go to z.
  - Asserts done=1 for one cycle, busy=0, goes to IDLE.
- Latency, fast responder (SSYN seen 2 cycles after MSYN by the synchroniser, drops 2 cycles after release):
  - req → done = 1 + DESKEW + 3 + 1 + 3 + DESKEW cycles.
  - DESKEW=4 gives 16 cycles.
- SSYN already low when entering ASSERT (stuck responder): treated as an immediate response. RELEASE then times out if SSYN never rises.
- req while busy: ignored, no queue.
- rdata is unchanged on writes and on timed-out reads.
- Timeout counter: 8+ bits wide, saturating compare at TIMEOUT, reset on each state entry.

Optional Feature:
- Macro OC_BUS_RETRY_EN.
- Defined:
  - An ASSERT-phase timeout does not set timeout on the first occurrence.
  - Instead the block completes RELEASE/HOLD with bus released, waits DESKEW idle cycles, and reruns SETUP once with the same latched request.
  - A second timeout sets timeout and ends normally with done.
  - done pulses only once per req.
- Undefined: the first timeout is final, as described above.

Test Plan:
- Read, responder returns 16'o123456 with SSYN 3 cycles after MSYN, DESKEW=4:
  - rdata=16'o123456, timeout=0, done exactly once.
  - bus_a_n = ~addr for the whole MSYN window.
  - Address stable ≥4 cycles on each side of MSYN.
- Write addr=18'o777560, wdata=16'o000101:
  - bus_d_n = ~wdata and bus_c1_n=0 from SETUP through HOLD.
  - msyn_n low until SSYN.
  - All lines z after done.
- No responder, TIMEOUT=20:
  - timeout=1, done pulses.
  - msyn_n low for exactly 20 cycles.
  - rdata unchanged.
  - With OC_BUS_RETRY_EN: two MSYN assertions, then timeout=1.
- Responder holds SSYN low 50 cycles after MSYN release, TIMEOUT=20:
  - RELEASE times out, timeout=1.
  - Bus released, block returns to IDLE.
- reset_n pulsed low while in ASSERT:
  - All bus lines z and busy=0 immediately.
  - A next req completes normally.
- req held high during a cycle, then a second req:
  - Exactly one cycle per accepted req.
  - The second read returns new data and clears the prior timeout flag.
